// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared encodings for the MiniAlu run-control sequencer
// Purpose: state codes, host command codes and default widths used by
//          alu_exec_controller and its testbench.
package alu_ctrl_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int CYC_W_DEF  = 32;

   typedef enum logic [2:0] {
      S_RST   = 3'd0,
      S_IDLE  = 3'd1,
      S_RUN   = 3'd2,
      S_STEP  = 3'd3,
      S_BREAK = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      CMD_RUN     = 2'b00,
      CMD_HALT    = 2'b01,
      CMD_STEP    = 2'b10,
      CMD_RESTART = 2'b11
   } cmd_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with sync clear
// Purpose: counts enabled cycles, sticks at all-ones instead of wrapping.
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset, count -> 0
//   clr_i    synchronous clear, takes priority over en_i
//   en_i     increment enable
//   count_o  current count
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/alu_exec_controller.sv
// rtl/alu_exec_controller.sv - run/halt/step/restart sequencer for MiniAlu
// Purpose: drives MiniAlu reset and global clock-enable from host commands,
//          with one IP breakpoint and a saturating executed-cycle count.
// Ports:
//   Clock, Reset               clock, asynchronous active-high reset
//   iCmdValid/iCmd/oCmdReady   host command handshake (RUN/HALT/STEP/RESTART)
//   iBreakEn/iBreakAddr        breakpoint enable and address
//   iIP                        current MiniAlu fetch address
//   oAluReset/oAluEnable       MiniAlu reset and clock-enable
//   oState                     current state code
//   oBreakHit                  one-cycle pulse on entering S_BREAK
//   oCycleCount                enabled cycles since last S_RST, saturating
module alu_exec_controller
   import alu_ctrl_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int CYC_W      = CYC_W_DEF,
   parameter int RESET_HOLD = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              iCmdValid,
   input  logic [1:0]        iCmd,
   output logic              oCmdReady,
   input  logic              iBreakEn,
   input  logic [ADDR_W-1:0] iBreakAddr,
   input  logic [ADDR_W-1:0] iIP,
   output logic              oAluReset,
   output logic              oAluEnable,
   output logic [2:0]        oState,
   output logic              oBreakHit,
   output logic [CYC_W-1:0]  oCycleCount
);

   localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);

   state_e            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              mask_q, mask_d;
   logic              hit_q, hit_d;
   logic              bm;
   logic              alu_reset;
   logic              alu_en;
   logic              cmd_ready;
   logic              cyc_clr;
   cmd_e              cmd;

   assign cmd = cmd_e'(iCmd);

   // Mask suppresses the match for the first cycle after resuming from a
   // breakpoint so the instruction sitting at the break address executes.
   assign bm = iBreakEn & (iIP == iBreakAddr) & ~mask_q;

   // In every state that accepts commands, ready is 1, so iCmdValid alone
   // qualifies a command inside those branches.
   always_comb begin
      state_d   = state_q;
      hold_d    = HOLD_INIT;
      mask_d    = mask_q;
      alu_reset = 1'b0;
      alu_en    = 1'b0;
      cmd_ready = 1'b0;
      case (state_q)
         S_RST: begin
            alu_reset = 1'b1;
            mask_d    = 1'b0;
            if (hold_q == '0) begin
               state_d = S_IDLE;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (iCmdValid) begin
               case (cmd)
                  CMD_RUN:     state_d = S_RUN;
                  CMD_STEP:    state_d = S_STEP;
                  CMD_RESTART: state_d = S_RST;
                  default:     state_d = S_IDLE;
               endcase
            end
         end
         S_RUN: begin
            cmd_ready = 1'b1;
            alu_en    = ~bm;
            mask_d    = 1'b0;
            // Host HALT/RESTART take priority over a breakpoint in the same cycle.
            if (iCmdValid && (cmd == CMD_HALT)) begin
               state_d = S_IDLE;
            end else if (iCmdValid && (cmd == CMD_RESTART)) begin
               state_d = S_RST;
            end else if (bm) begin
               state_d = S_BREAK;
            end
         end
         S_STEP: begin
            alu_en  = 1'b1;
            state_d = S_IDLE;
         end
         S_BREAK: begin
            cmd_ready = 1'b1;
            if (iCmdValid) begin
               case (cmd)
                  CMD_RUN: begin
                     state_d = S_RUN;
                     mask_d  = 1'b1;
                  end
                  CMD_STEP:    state_d = S_STEP;
                  CMD_HALT:    state_d = S_IDLE;
                  CMD_RESTART: state_d = S_RST;
                  default:     state_d = S_BREAK;
               endcase
            end
         end
         default: begin
            state_d = S_RST;
         end
      endcase
      hit_d = (state_d == S_BREAK) && (state_q != S_BREAK);
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= S_RST;
         hold_q  <= HOLD_INIT;
         mask_q  <= 1'b0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         mask_q  <= mask_d;
         hit_q   <= hit_d;
      end
   end

   assign cyc_clr = (state_q == S_RST);

   sat_counter #(
      .W(CYC_W)
   ) u_cycle_count (
      .clk_i   (Clock),
      .rst_i   (Reset),
      .clr_i   (cyc_clr),
      .en_i    (alu_en),
      .count_o (oCycleCount)
   );

   assign oCmdReady  = cmd_ready;
   assign oAluReset  = alu_reset;
   assign oAluEnable = alu_en;
   assign oState     = state_q;
   assign oBreakHit  = hit_q;

endmodule

// File: tb/tb_alu_exec_controller.sv
// tb/tb_alu_exec_controller.sv - self-checking bench for alu_exec_controller
module tb_alu_exec_controller;
   import alu_ctrl_pkg::*;

   logic        Clock;
   logic        Reset;
   logic        iCmdValid;
   logic [1:0]  iCmd;
   logic        iBreakEn;
   logic [15:0] iBreakAddr;
   logic [15:0] iIP;
   logic        oCmdReady;
   logic        oAluReset;
   logic        oAluEnable;
   logic [2:0]  oState;
   logic        oBreakHit;
   logic [31:0] oCycleCount;

   logic        r4_ready;
   logic        r4_reset;
   logic        r4_en;
   logic [2:0]  r4_state;
   logic        r4_hit;
   logic [3:0]  r4_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          hit_cnt  = 0;
   logic [15:0] exp_ip_q[$];

   alu_exec_controller #(.ADDR_W(16), .CYC_W(32), .RESET_HOLD(4)) dut (
      .Clock(Clock), .Reset(Reset), .iCmdValid(iCmdValid), .iCmd(iCmd),
      .oCmdReady(oCmdReady), .iBreakEn(iBreakEn), .iBreakAddr(iBreakAddr),
      .iIP(iIP), .oAluReset(oAluReset), .oAluEnable(oAluEnable),
      .oState(oState), .oBreakHit(oBreakHit), .oCycleCount(oCycleCount)
   );

   alu_exec_controller #(.ADDR_W(16), .CYC_W(4), .RESET_HOLD(4)) dut4 (
      .Clock(Clock), .Reset(Reset), .iCmdValid(iCmdValid), .iCmd(iCmd),
      .oCmdReady(r4_ready), .iBreakEn(iBreakEn), .iBreakAddr(iBreakAddr),
      .iIP(iIP), .oAluReset(r4_reset), .oAluEnable(r4_en),
      .oState(r4_state), .oBreakHit(r4_hit), .oCycleCount(r4_count)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Minimal MiniAlu stand-in: IP advances only on enabled cycles.
   always @(posedge Clock) begin
      if (oAluReset) begin
         iIP <= 16'd0;
      end else if (oAluEnable) begin
         iIP <= iIP + 16'd1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every enabled cycle must execute the next expected IP.
   always @(negedge Clock) begin
      if (!Reset && oAluEnable === 1'b1) begin
         if (exp_ip_q.size() == 0) begin
            check("unexp_enable", {31'd0, oAluEnable}, 32'd0);
         end else begin
            check("exec_ip", {16'd0, iIP}, {16'd0, exp_ip_q.pop_front()});
         end
      end
      if (!Reset && oBreakHit === 1'b1) hit_cnt++;
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic send(input logic [1:0] c);
      iCmdValid = 1'b1;
      iCmd      = c;
      tick();
      iCmdValid = 1'b0;
   endtask

   task automatic push_ips(input int first, input int n);
      for (int i = 0; i < n; i++) exp_ip_q.push_back(16'(first + i));
   endtask

   task automatic wait_reset_exit(input string tag);
      int n;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge Clock);
         if (oAluReset) n++;
      end
      check({tag, "_hold"},  n, 4);
      check({tag, "_state"}, {29'd0, oState}, {29'd0, S_IDLE});
      check({tag, "_count"}, oCycleCount, 32'd0);
      check({tag, "_ready"}, {31'd0, oCmdReady}, 32'd1);
      check({tag, "_en"},    {31'd0, oAluEnable}, 32'd0);
   endtask

   task automatic restart(input string tag);
      send(CMD_RESTART);
      wait_reset_exit(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic seen;
      Reset      = 1'b1;
      iCmdValid  = 1'b0;
      iCmd       = CMD_HALT;
      iBreakEn   = 1'b0;
      iBreakAddr = 16'd0;

      // 1: reset state and hold length
      repeat (2) @(negedge Clock);
      check("rst_state", {29'd0, oState}, {29'd0, S_RST});
      check("rst_alureset", {31'd0, oAluReset}, 32'd1);
      check("rst_ready", {31'd0, oCmdReady}, 32'd0);
      check("rst_hit", {31'd0, oBreakHit}, 32'd0);
      check("rst_count", oCycleCount, 32'd0);
      tick();
      Reset = 1'b0;
      wait_reset_exit("rst");

      // 2: free run for 10 cycles then halt
      push_ips(0, 10);
      send(CMD_RUN);
      repeat (9) tick();
      send(CMD_HALT);
      @(negedge Clock);
      check("run_state", {29'd0, oState}, {29'd0, S_IDLE});
      check("run_count", oCycleCount, 32'd10);

      // 3: breakpoint at 5, then resume past it
      restart("r3");
      hit_cnt    = 0;
      iBreakAddr = 16'd5;
      iBreakEn   = 1'b1;
      push_ips(0, 5);
      send(CMD_RUN);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge Clock);
         if (oBreakHit) seen = 1'b1;
      end
      check("bp_seen", {31'd0, seen}, 32'd1);
      check("bp_ip", {16'd0, iIP}, 32'd5);
      check("bp_count", oCycleCount, 32'd5);
      check("bp_state", {29'd0, oState}, {29'd0, S_BREAK});
      check("bp_en", {31'd0, oAluEnable}, 32'd0);
      @(negedge Clock);
      check("bp_pulse", {31'd0, oBreakHit}, 32'd0);
      push_ips(5, 5);
      send(CMD_RUN);
      repeat (4) tick();
      send(CMD_HALT);
      @(negedge Clock);
      check("bp2_state", {29'd0, oState}, {29'd0, S_IDLE});
      check("bp2_count", oCycleCount, 32'd10);
      check("bp2_ip", {16'd0, iIP}, 32'd10);
      check("bp2_hits", hit_cnt, 1);

      // 4: three single steps
      iBreakEn = 1'b0;
      restart("r4");
      for (int k = 0; k < 3; k++) begin
         push_ips(k, 1);
         send(CMD_STEP);
         @(negedge Clock);
         check("step_state", {29'd0, oState}, {29'd0, S_STEP});
         check("step_ready", {31'd0, oCmdReady}, 32'd0);
         check("step_en", {31'd0, oAluEnable}, 32'd1);
         @(negedge Clock);
         check("step_idle", {29'd0, oState}, {29'd0, S_IDLE});
      end
      check("step_count", oCycleCount, 32'd3);

      // 5: HALT lands in the same cycle as a break match
      restart("r5");
      hit_cnt    = 0;
      iBreakAddr = 16'd3;
      iBreakEn   = 1'b1;
      push_ips(0, 3);
      send(CMD_RUN);
      repeat (3) tick();
      check("hb_en", {31'd0, oAluEnable}, 32'd0);
      send(CMD_HALT);
      @(negedge Clock);
      check("hb_state", {29'd0, oState}, {29'd0, S_IDLE});
      check("hb_count", oCycleCount, 32'd3);
      @(negedge Clock);
      check("hb_hits", hit_cnt, 0);
      // RESTART while running
      iBreakEn = 1'b0;
      push_ips(3, 3);
      send(CMD_RUN);
      repeat (2) tick();
      restart("rr");
      check("rr_ip", {16'd0, iIP}, 32'd0);

      // 6: saturation with a 4-bit counter instance
      push_ips(0, 20);
      send(CMD_RUN);
      repeat (19) tick();
      send(CMD_HALT);
      @(negedge Clock);
      check("sat_count32", oCycleCount, 32'd20);
      check("sat_count4", {28'd0, r4_count}, 32'd15);
      check("sat_state4", {29'd0, r4_state}, {29'd0, S_IDLE});
      // async reset in the middle of a step
      send(CMD_STEP);
      #1;
      Reset = 1'b1;
      #1;
      check("ar_en", {31'd0, oAluEnable}, 32'd0);
      check("ar_state", {29'd0, oState}, {29'd0, S_RST});
      check("ar_alureset", {31'd0, oAluReset}, 32'd1);
      tick();
      Reset = 1'b0;
      wait_reset_exit("ar");

      check("sb_empty", exp_ip_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
